// File: rtl/fir_tap_multiplier.sv
// -----------------------------------------------------------------------------
// fir_tap_multiplier
//
// Front end of a direct-form FIR filter: a TAPS-deep signed sample delay line,
// a writable TAPS-entry coefficient bank and one registered full-precision
// product per tap. The products feed an external adder tree.
//
// Pipeline:
//   stage 1 : accepted sample shifts into the delay line; valid1_q marks it.
//   stage 2 : every tap is multiplied by its coefficient and registered;
//             out_valid follows valid1_q by one cycle (latency 2).
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous, active-high reset
//   in_valid       in   sample_in is valid this cycle
//   sample_in      in   signed sample, DATABITS wide
//   coef_we        in   coefficient write enable
//   coef_addr      in   coefficient index (writes at index >= TAPS are dropped)
//   coef_data      in   signed coefficient, COEFBITS wide
//   multiplier_out out  registered products, one per tap
//   out_valid      out  multiplier_out holds a new product set this cycle
//   primed         out  at least TAPS samples have reached the products
// -----------------------------------------------------------------------------
module fir_tap_multiplier #(
    parameter int unsigned TAPS     = 401,
    parameter int unsigned DATABITS = 16,
    parameter int unsigned COEFBITS = 16,
    parameter int unsigned MULTBITS = DATABITS + COEFBITS,
    // Wider than $clog2(TAPS) only when a bench needs to drive indices that
    // are not representable in the natural width.
    parameter int unsigned ADDRBITS = $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DATABITS-1:0] sample_in,
    input  logic                       coef_we,
    input  logic        [ADDRBITS-1:0] coef_addr,
    input  logic signed [COEFBITS-1:0] coef_data,
    output logic signed [MULTBITS-1:0] multiplier_out [0:TAPS-1],
    output logic                       out_valid,
    output logic                       primed
);

    // Fill counter must be able to represent TAPS itself.
    localparam int unsigned CNTBITS = $clog2(TAPS + 1);
    localparam logic [CNTBITS-1:0] FillMax = CNTBITS'(TAPS);

    logic signed [DATABITS-1:0] tap_q  [0:TAPS-1];
    logic signed [DATABITS-1:0] tap_d  [0:TAPS-1];
    logic signed [COEFBITS-1:0] coef_q [0:TAPS-1];
    logic signed [COEFBITS-1:0] coef_d [0:TAPS-1];
    logic signed [MULTBITS-1:0] prod_q [0:TAPS-1];
    logic signed [MULTBITS-1:0] prod_d [0:TAPS-1];

    logic               valid1_q, valid1_d;
    logic               out_valid_q, out_valid_d;
    logic [CNTBITS-1:0] fill_q, fill_d;
    logic               primed_q, primed_d;

    // ------------------------------------------------------------------
    // Stage 1: delay line
    // ------------------------------------------------------------------
    always_comb begin
        tap_d = tap_q;
        if (in_valid) begin
            tap_d[0] = sample_in;
            for (int unsigned k = 1; k < TAPS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank
    // ------------------------------------------------------------------
    // Address decode by comparison rather than indexing, so an index that
    // is out of range can never alias onto a real entry.
    always_comb begin
        coef_d = coef_q;
        if (coef_we) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (32'(coef_addr) == k) begin
                    coef_d[k] = coef_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: products
    // ------------------------------------------------------------------
    // Operands are sign-extended to the product width first, so the
    // multiply is exact (including the most-negative * most-negative case).
    // The coefficient read is the registered bank, so a write on the same
    // edge that a sample is accepted is seen by that sample's products.
    always_comb begin
        prod_d = prod_q;
        if (valid1_q) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                prod_d[k] = MULTBITS'(tap_q[k]) * MULTBITS'(coef_q[k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid pipeline, fill counter and primed flag
    // ------------------------------------------------------------------
    always_comb begin
        valid1_d    = in_valid;
        out_valid_d = valid1_q;

        fill_d = fill_q;
        if (in_valid && (fill_q != FillMax)) begin
            fill_d = fill_q + 1'b1;
        end

        // fill_q reaches TAPS one cycle after the TAPS-th sample is accepted,
        // which is exactly when that sample sits in stage 1; setting primed on
        // that edge makes it rise together with the matching out_valid.
        primed_d = primed_q | (valid1_q & (fill_q == FillMax));
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q       <= '{default: '0};
            coef_q      <= '{default: '0};
            prod_q      <= '{default: '0};
            valid1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            fill_q      <= '0;
            primed_q    <= 1'b0;
        end else begin
            tap_q       <= tap_d;
            coef_q      <= coef_d;
            prod_q      <= prod_d;
            valid1_q    <= valid1_d;
            out_valid_q <= out_valid_d;
            fill_q      <= fill_d;
            primed_q    <= primed_d;
        end
    end

    assign multiplier_out = prod_q;
    assign out_valid      = out_valid_q;
    assign primed         = primed_q;

endmodule

// File: doc/fir_tap_multiplier.md
FIR_TAP_MULTIPLIER -- requirements
Module: fir_tap_multiplier

Interface
REQ-001 SHALL have parameter TAPS, default 401, number of filter taps.
REQ-002 SHALL have parameter DATABITS, default 16, signed input sample width.
REQ-003 SHALL have parameter COEFBITS, default 16, signed coefficient width.
REQ-004 SHALL have parameter MULTBITS, default 32, product width; SHALL equal DATABITS+COEFBITS.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port in_valid  input  1  sample_in is valid this cycle.
REQ-008 SHALL have port sample_in  input  DATABITS  signed input sample.
REQ-009 SHALL have port coef_we  input  1  coefficient write enable.
REQ-010 SHALL have port coef_addr  input  $clog2(TAPS)  coefficient index.
REQ-011 SHALL have port coef_data  input  COEFBITS  signed coefficient value.
REQ-012 SHALL have port multiplier_out  output  MULTBITS x [0:TAPS-1]  registered products for the downstream adder tree.
REQ-013 SHALL have port out_valid  output  1  multiplier_out holds a new product set this cycle.
REQ-014 SHALL have port primed  output  1  delay line has received at least TAPS samples since reset.

Function
REQ-015 SHALL hold a TAPS-deep signed delay line tap[0..TAPS-1] and a TAPS-entry coefficient bank coef[0..TAPS-1].
REQ-016 On an edge with in_valid=1: tap[0]<=sample_in, tap[k]<=tap[k-1] for k=1..TAPS-1; delay line SHALL hold its value when in_valid=0.
REQ-017 Stage 2 SHALL register multiplier_out[k]<=tap[k]*coef[k], full-precision signed, no rounding or truncation, only on edges where the stage-1 valid flag (in_valid delayed one cycle) is 1; otherwise multiplier_out SHALL hold.
REQ-018 out_valid SHALL be the stage-1 valid flag delayed one cycle; a sample accepted in cycle N SHALL produce out_valid=1 in cycle N+2 (latency 2), one cycle per accepted sample.
REQ-019 Back-to-back in_valid SHALL sustain throughput of one product set per cycle; no backpressure exists.
REQ-020 On an edge with coef_we=1 and coef_addr<TAPS, coef[coef_addr]<=coef_data; coef_addr>=TAPS SHALL be ignored with no state change.
REQ-021 A coefficient written on edge E SHALL first be used by products registered on edge E+1 or later; products registered on edge E use the old value.
REQ-022 Simultaneous coef_we and in_valid SHALL both take effect on the same edge, independently.
REQ-023 A fill counter SHALL increment per accepted sample, saturating at TAPS; primed SHALL be 1 in and after the cycle whose out_valid reflects the TAPS-th accepted sample, and SHALL stay 1 until reset.
REQ-024 Product sign: MSB of multiplier_out[k] SHALL be the two's-complement sign; (-2^(DATABITS-1))*(-2^(COEFBITS-1)) SHALL yield +2^(MULTBITS-2) without overflow.

Reset
REQ-025 When rst=1 at an edge: all tap[k]=0, all coef[k]=0, all multiplier_out[k]=0, out_valid=0, primed=0, fill counter=0, stage-1 valid=0.
REQ-026 rst SHALL take priority over in_valid and coef_we on the same edge; in-flight samples SHALL be discarded and no out_valid pulse SHALL follow for them.
REQ-027 First sample after reset deassertion SHALL see an all-zero delay line behind it.

Verification (TAPS=4, DATABITS=COEFBITS=16)
REQ-028 Impulse: coef={1,2,3,4}; samples 1,0,0,0 on consecutive cycles -> successive out_valid sets multiplier_out={1,0,0,0},{0,2,0,0},{0,0,3,0},{0,0,0,4}; primed rises with the fourth set.
REQ-029 Signed corners: coef[0]=-5, sample -3 -> multiplier_out[0]=15; coef[0]=0x8000, sample 0x8000 -> multiplier_out[0]=0x40000000; coef[0]=0x7FFF, sample 0x8000 -> 0xC0008000.
REQ-030 Gapped input: in_valid pattern 1,0,0,1 -> exactly two out_valid pulses at cycles 2 and 5; multiplier_out unchanged between them.
REQ-031 Coefficient timing: coef[0]=2, write coef[0]=7 on the same edge a sample 1 is accepted -> its product is 7; write issued on the edge it enters stage 2 -> product 2; write to coef_addr=5 (4-bit port, TAPS=4) -> no coefficient changes.
REQ-032 Reset mid-stream: assert rst one cycle after in_valid with sample 9 -> no out_valid follows, all outputs 0, primed 0; next sample 1 with coef={1,1,1,1} yields {1,0,0,0}.
